// File: rtl/qspi_fifo_pkg.sv
// Shared defaults, ratio helper and stored-entry layout for the QSPI receive pack FIFO.
package qspi_fifo_pkg;

   localparam int DEF_WR_WIDTH   = 8;
   localparam int DEF_RD_WIDTH   = 32;
   localparam int DEF_FIFO_DEPTH = 16;

   // Number of input units that make up one stored word.
   function automatic int calc_ratio(input int wr_width, input int rd_width);
      return rd_width / wr_width;
   endfunction

   // True when the input unit width evenly divides the word width.
   function automatic bit width_ok(input int wr_width, input int rd_width);
      return (wr_width > 0) && (rd_width >= wr_width) && ((rd_width % wr_width) == 0);
   endfunction

   // True when the depth is a power of two of at least two.
   function automatic bit depth_ok(input int depth);
      return (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

   // Stored entry for the default configuration: word plus per-unit valid mask.
   typedef struct packed {
      logic [DEF_RD_WIDTH-1:0]                              data;
      logic [calc_ratio(DEF_WR_WIDTH, DEF_RD_WIDTH)-1:0]    be;
   } entry_t;

endpackage

// File: rtl/qspi_rx_pack_fifo_if.sv
// Bus bundle between the QSPI receive shifter / AHB read side and the pack FIFO.
interface qspi_rx_pack_fifo_if
   import qspi_fifo_pkg::*;
#(
   parameter int WR_WIDTH   = DEF_WR_WIDTH,
   parameter int RD_WIDTH   = DEF_RD_WIDTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) ();

   localparam int R  = calc_ratio(WR_WIDTH, RD_WIDTH);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic                wr_en;
   logic [WR_WIDTH-1:0] wr_data;
   logic                flush_partial;
   logic                wr_ready;
   logic                rd_en;
   logic [RD_WIDTH-1:0] rd_data;
   logic [R-1:0]        rd_be;
   logic                full;
   logic                empty;
   logic                almost_full;
   logic                almost_empty;
   logic [LW-1:0]       level;
   logic                overflow;
   logic                underflow;

   modport master (
      output wr_en, wr_data, flush_partial, rd_en,
      input  wr_ready, rd_data, rd_be, full, empty, almost_full, almost_empty,
             level, overflow, underflow
   );

   modport slave (
      input  wr_en, wr_data, flush_partial, rd_en,
      output wr_ready, rd_data, rd_be, full, empty, almost_full, almost_empty,
             level, overflow, underflow
   );

endinterface

// File: rtl/qspi_rx_packer.sv
// Little-endian unit packer: collects input units into one word and emits a push
// with data and per-unit valid mask when the word completes or is flushed early.
module qspi_rx_packer
   import qspi_fifo_pkg::*;
#(
   parameter  int WR_WIDTH = DEF_WR_WIDTH,
   parameter  int RD_WIDTH = DEF_RD_WIDTH,
   localparam int R        = calc_ratio(WR_WIDTH, RD_WIDTH),
   localparam int CW       = (R > 1) ? $clog2(R) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic                i_wr_en,
   input  logic [WR_WIDTH-1:0] i_wr_data,
   input  logic                i_flush,
   input  logic                i_ready,
   output logic                o_push,
   output logic [RD_WIDTH-1:0] o_data,
   output logic [R-1:0]        o_be
);

   logic [CW-1:0]       r_cnt;
   logic [RD_WIDTH-1:0] r_data;
   logic                w_wr_acc;
   logic                w_fl_acc;
   logic                w_last;
   logic [RD_WIDTH-1:0] w_asm;
   logic [RD_WIDTH-1:0] w_mask;
   logic [R-1:0]        w_be;

   // Nothing is taken while the FIFO is full; the packer then stays untouched.
   assign w_wr_acc = i_wr_en & i_ready;
   assign w_fl_acc = i_flush & i_ready;
   assign w_last   = (int'(r_cnt) == R - 1);

   // Merge the incoming unit into its slot and build the valid mask; invalid slots are zeroed.
   always_comb begin
      w_asm  = r_data;
      w_be   = '0;
      w_mask = '0;
      for (int k = 0; k < R; k++) begin
         if (k < int'(r_cnt)) begin
            w_be[k] = 1'b1;
         end
         if (w_wr_acc && (k == int'(r_cnt))) begin
            w_be[k]                         = 1'b1;
            w_asm[k*WR_WIDTH +: WR_WIDTH]   = i_wr_data;
         end
         w_mask[k*WR_WIDTH +: WR_WIDTH] = {WR_WIDTH{w_be[k]}};
      end
   end

   // A word leaves when the last slot fills, or on a flush that has at least one unit.
   assign o_push = (w_wr_acc && w_last) || (w_fl_acc && ((r_cnt != '0) || w_wr_acc));
   assign o_data = w_asm & w_mask;
   assign o_be   = w_be;

   // Slot counter: cleared on reset/clear and whenever a word leaves, else steps per unit.
   always_ff @(posedge clk) begin
      if (rst_n || clear) begin
         r_cnt <= '0;
      end else if (o_push) begin
         r_cnt <= '0;
      end else if (w_wr_acc) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // Unit storage; stale slots are masked off on output so this needs no reset.
   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_data <= w_asm;
      end
   end

endmodule

// File: rtl/qspi_rx_pack_fifo.sv
// QSPI receive FIFO: packs narrow units into words, stores word + valid mask,
// and serves the AHB side in registered or show-ahead read mode.
module qspi_rx_pack_fifo
   import qspi_fifo_pkg::*;
#(
   parameter int WR_WIDTH   = DEF_WR_WIDTH,
   parameter int RD_WIDTH   = DEF_RD_WIDTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int AF_THRESH  = FIFO_DEPTH - 2,
   parameter int AE_THRESH  = 1,
   parameter bit SHOW_AHEAD = 1'b0
) (
   input logic                clk,
   input logic                rst_n,
   input logic                clear,
   qspi_rx_pack_fifo_if.slave bus
);

   localparam int R  = calc_ratio(WR_WIDTH, RD_WIDTH);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   typedef struct packed {
      logic [RD_WIDTH-1:0] data;
      logic [R-1:0]        be;
   } mem_entry_t;

   if (!width_ok(WR_WIDTH, RD_WIDTH)) begin : g_bad_width
      $error("qspi_rx_pack_fifo: WR_WIDTH must divide RD_WIDTH");
   end
   if (!depth_ok(FIFO_DEPTH)) begin : g_bad_depth
      $error("qspi_rx_pack_fifo: FIFO_DEPTH must be a power of two >= 2");
   end

   logic [AW-1:0]       r_wptr;
   logic [AW-1:0]       r_rptr;
   logic [LW-1:0]       r_level;
   logic                r_overflow;
   logic                r_underflow;
   mem_entry_t          r_mem [FIFO_DEPTH];

   logic                w_rst;
   logic                w_full;
   logic                w_empty;
   logic                w_push;
   logic                w_pop;
   logic [RD_WIDTH-1:0] w_pk_data;
   logic [R-1:0]        w_pk_be;
   mem_entry_t          w_head;

   // Soft clear behaves exactly like reset and wins over any same-cycle operation.
   assign w_rst   = rst_n | clear;
   assign w_full  = (r_level == LW'(FIFO_DEPTH));
   assign w_empty = (r_level == '0);
   assign w_pop   = bus.rd_en & ~w_empty;
   assign w_head  = r_mem[r_rptr];

   // Readiness depends only on full, so a write never relies on a same-cycle pop.
   qspi_rx_packer #(
      .WR_WIDTH (WR_WIDTH),
      .RD_WIDTH (RD_WIDTH)
   ) u_packer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .i_wr_en   (bus.wr_en),
      .i_wr_data (bus.wr_data),
      .i_flush   (bus.flush_partial),
      .i_ready   (~w_full),
      .o_push    (w_push),
      .o_data    (w_pk_data),
      .o_be      (w_pk_be)
   );

   // Word storage; only written by a push, contents are don't-care until pushed.
   always_ff @(posedge clk) begin
      if (w_push && !w_rst) begin
         r_mem[r_wptr] <= '{data: w_pk_data, be: w_pk_be};
      end
   end

   // Pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk) begin
      if (w_rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
      end
   end

   // Fill level as an up/down counter; push and pop together cancel out.
   always_ff @(posedge clk) begin
      if (w_rst) begin
         r_level <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Sticky errors: any write attempt while full, any pop attempt while empty.
   always_ff @(posedge clk) begin
      if (w_rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if ((bus.wr_en || bus.flush_partial) && w_full) begin
            r_overflow <= 1'b1;
         end
         if (bus.rd_en && w_empty) begin
            r_underflow <= 1'b1;
         end
      end
   end

   if (SHOW_AHEAD) begin : g_show_ahead
      // Head word is presented directly; an empty FIFO shows zero.
      assign bus.rd_data = w_empty ? '0 : w_head.data;
      assign bus.rd_be   = w_empty ? '0 : w_head.be;
   end else begin : g_registered
      logic [RD_WIDTH-1:0] r_rd_data;
      logic [R-1:0]        r_rd_be;

      // Output register loads the head on a legal pop and holds otherwise.
      always_ff @(posedge clk) begin
         if (w_rst) begin
            r_rd_data <= '0;
            r_rd_be   <= '0;
         end else if (w_pop) begin
            r_rd_data <= w_head.data;
            r_rd_be   <= w_head.be;
         end
      end

      assign bus.rd_data = r_rd_data;
      assign bus.rd_be   = r_rd_be;
   end

   assign bus.wr_ready     = ~w_full;
   assign bus.full         = w_full;
   assign bus.empty        = w_empty;
   assign bus.almost_full  = (r_level >= LW'(AF_THRESH));
   assign bus.almost_empty = (r_level <= LW'(AE_THRESH));
   assign bus.level        = r_level;
   assign bus.overflow     = r_overflow;
   assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_qspi_rx_pack_fifo.sv
// Directed bench for the QSPI receive pack FIFO: one registered-read instance
// and one show-ahead instance sharing clock and reset.
module tb_qspi_rx_pack_fifo;
   import qspi_fifo_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic clr0 = 1'b0;
   logic clr1 = 1'b0;

   always #5 clk = ~clk;

   qspi_rx_pack_fifo_if #(.WR_WIDTH(8), .RD_WIDTH(32), .FIFO_DEPTH(16)) if0 ();
   qspi_rx_pack_fifo_if #(.WR_WIDTH(8), .RD_WIDTH(32), .FIFO_DEPTH(16)) if1 ();

   qspi_rx_pack_fifo #(
      .WR_WIDTH(8), .RD_WIDTH(32), .FIFO_DEPTH(16),
      .AF_THRESH(14), .AE_THRESH(1), .SHOW_AHEAD(1'b0)
   ) u0 (
      .clk   (clk),
      .rst_n (rst),
      .clear (clr0),
      .bus   (if0.slave)
   );

   qspi_rx_pack_fifo #(
      .WR_WIDTH(8), .RD_WIDTH(32), .FIFO_DEPTH(16),
      .AF_THRESH(14), .AE_THRESH(1), .SHOW_AHEAD(1'b1)
   ) u1 (
      .clk   (clk),
      .rst_n (rst),
      .clear (clr1),
      .bus   (if1.slave)
   );

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      bit          wr;
      logic [7:0]  d;
      bit          fl;
      bit          rd;
      int          lvl;
      bit          cd;
      logic [31:0] dat;
      logic [3:0]  be;
   } vec_t;

   vec_t vt[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Drive one cycle on instance s (0 = registered, 1 = show-ahead), other idle.
   task automatic step(input bit s, input bit wr, input logic [7:0] d, input bit fl,
                       input bit rd, input bit cl);
      if0.wr_en         = !s && wr;
      if0.wr_data       = d;
      if0.flush_partial = !s && fl;
      if0.rd_en         = !s && rd;
      if1.wr_en         = s && wr;
      if1.wr_data       = d;
      if1.flush_partial = s && fl;
      if1.rd_en         = s && rd;
      clr0              = !s && cl;
      clr1              = s && cl;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(0, 0, 8'h00, 0, 0, 0);
      step(0, 0, 8'h00, 0, 0, 0);
      rst = 1'b0;
   endtask

   task automatic add(input bit wr, input logic [7:0] d, input bit fl, input bit rd,
                      input int lvl, input bit cd, input logic [31:0] dat, input logic [3:0] be);
      vec_t v;
      v.wr = wr; v.d = d; v.fl = fl; v.rd = rd;
      v.lvl = lvl; v.cd = cd; v.dat = dat; v.be = be;
      vt.push_back(v);
   endtask

   logic [31:0] exp_w;
   int          rd_cnt;
   bit          rdq;
   int          k;

   initial begin
      if0.wr_en = 0; if0.wr_data = 0; if0.flush_partial = 0; if0.rd_en = 0;
      if1.wr_en = 0; if1.wr_data = 0; if1.flush_partial = 0; if1.rd_en = 0;

      // Test 1: eight bytes, two reads; test 2: partial flush and flush corners
      add(1, 8'h11, 0, 0, 0, 0, 32'h0, 4'h0);
      add(1, 8'h22, 0, 0, 0, 0, 32'h0, 4'h0);
      add(1, 8'h33, 0, 0, 0, 0, 32'h0, 4'h0);
      add(1, 8'h44, 0, 0, 1, 0, 32'h0, 4'h0);
      add(1, 8'h55, 0, 0, 1, 0, 32'h0, 4'h0);
      add(1, 8'h66, 0, 0, 1, 0, 32'h0, 4'h0);
      add(1, 8'h77, 0, 0, 1, 0, 32'h0, 4'h0);
      add(1, 8'h88, 0, 0, 2, 1, 32'h0, 4'h0);
      add(0, 8'h00, 0, 1, 1, 1, 32'h44332211, 4'hF);
      add(0, 8'h00, 0, 1, 0, 1, 32'h88776655, 4'hF);
      add(0, 8'h00, 0, 0, 0, 1, 32'h88776655, 4'hF);
      add(1, 8'hAA, 0, 0, 0, 0, 32'h0, 4'h0);
      add(1, 8'hBB, 0, 0, 0, 0, 32'h0, 4'h0);
      add(1, 8'hCC, 0, 0, 0, 0, 32'h0, 4'h0);
      add(0, 8'h00, 1, 0, 1, 0, 32'h0, 4'h0);
      add(0, 8'h00, 1, 0, 1, 0, 32'h0, 4'h0);
      add(0, 8'h00, 0, 1, 0, 1, 32'h00CCBBAA, 4'h7);
      add(1, 8'h01, 0, 0, 0, 0, 32'h0, 4'h0);
      add(1, 8'h02, 0, 0, 0, 0, 32'h0, 4'h0);
      add(1, 8'h03, 0, 0, 0, 0, 32'h0, 4'h0);
      add(1, 8'h04, 1, 0, 1, 0, 32'h0, 4'h0);
      add(0, 8'h00, 0, 0, 1, 0, 32'h0, 4'h0);
      add(0, 8'h00, 0, 1, 0, 1, 32'h04030201, 4'hF);
      add(1, 8'h5A, 0, 0, 0, 0, 32'h0, 4'h0);
      add(1, 8'h6B, 1, 0, 1, 0, 32'h0, 4'h0);
      add(0, 8'h00, 0, 1, 0, 1, 32'h00006B5A, 4'h3);

      do_reset();
      chk("rst level", 32'(if0.level), 32'd0);
      chk("rst empty", 32'(if0.empty), 32'd1);
      chk("rst full", 32'(if0.full), 32'd0);
      chk("rst wr_ready", 32'(if0.wr_ready), 32'd1);
      chk("rst almost_empty", 32'(if0.almost_empty), 32'd1);
      chk("rst almost_full", 32'(if0.almost_full), 32'd0);
      chk("rst rd_data", if0.rd_data, 32'h0);
      chk("rst rd_be", 32'(if0.rd_be), 32'h0);
      chk("rst overflow", 32'(if0.overflow), 32'd0);
      chk("rst underflow", 32'(if0.underflow), 32'd0);

      for (int i = 0; i < vt.size(); i++) begin
         step(0, vt[i].wr, vt[i].d, vt[i].fl, vt[i].rd, 0);
         chk($sformatf("v%0d level", i), 32'(if0.level), 32'(vt[i].lvl));
         chk($sformatf("v%0d empty", i), 32'(if0.empty), (vt[i].lvl == 0) ? 32'd1 : 32'd0);
         if (vt[i].cd) begin
            chk($sformatf("v%0d rd_data", i), if0.rd_data, vt[i].dat);
            chk($sformatf("v%0d rd_be", i), 32'(if0.rd_be), 32'(vt[i].be));
         end
      end

      // Test 3: fill to full, almost_full threshold, overflow, order kept
      do_reset();
      for (int i = 0; i < 64; i++) begin
         step(0, 1, 8'(i), 0, 0, 0);
         if ((i % 4) == 3) begin
            k = (i + 1) / 4;
            chk($sformatf("t3 level w%0d", k), 32'(if0.level), 32'(k));
            chk($sformatf("t3 almost_full w%0d", k), 32'(if0.almost_full), (k >= 14) ? 32'd1 : 32'd0);
            chk($sformatf("t3 full w%0d", k), 32'(if0.full), (k == 16) ? 32'd1 : 32'd0);
         end
      end
      chk("t3 wr_ready", 32'(if0.wr_ready), 32'd0);
      chk("t3 overflow pre", 32'(if0.overflow), 32'd0);
      step(0, 1, 8'hFF, 0, 0, 0);
      chk("t3 overflow", 32'(if0.overflow), 32'd1);
      chk("t3 level after ovf", 32'(if0.level), 32'd16);
      step(0, 0, 8'h00, 0, 1, 0);
      chk("t3 first word", if0.rd_data, 32'h03020100);
      chk("t3 level after rd", 32'(if0.level), 32'd15);
      chk("t3 overflow sticky", 32'(if0.overflow), 32'd1);

      // Test 4: streaming with reads as soon as a word is available
      do_reset();
      rd_cnt = 0;
      rdq    = 1'b0;
      for (int i = 0; i < 170; i++) begin
         step(0, (i < 160), 8'(i), 0, rdq, 0);
         if (rdq) begin
            exp_w = {8'(4*rd_cnt+3), 8'(4*rd_cnt+2), 8'(4*rd_cnt+1), 8'(4*rd_cnt)};
            chk($sformatf("t4 word%0d", rd_cnt), if0.rd_data, exp_w);
            rd_cnt++;
         end
         chk($sformatf("t4 level<=1 c%0d", i), (if0.level <= 5'd1) ? 32'd1 : 32'd0, 32'd1);
         rdq = !if0.empty;
      end
      chk("t4 words read", 32'(rd_cnt), 32'd40);
      chk("t4 overflow", 32'(if0.overflow), 32'd0);
      chk("t4 underflow", 32'(if0.underflow), 32'd0);

      // Test 5: underflow, clear, clear mid-packing
      do_reset();
      step(0, 0, 8'h00, 0, 1, 0);
      chk("t5 underflow", 32'(if0.underflow), 32'd1);
      chk("t5 rd_data", if0.rd_data, 32'h0);
      chk("t5 level", 32'(if0.level), 32'd0);
      step(0, 0, 8'h00, 0, 0, 1);
      chk("t5 underflow cleared", 32'(if0.underflow), 32'd0);
      for (int i = 0; i < 22; i++) begin
         step(0, 1, 8'(8'h30 + i), 0, 0, 0);
      end
      chk("t5 level 5", 32'(if0.level), 32'd5);
      step(0, 1, 8'hEE, 0, 0, 1);
      chk("t5 level clr", 32'(if0.level), 32'd0);
      chk("t5 empty clr", 32'(if0.empty), 32'd1);
      step(0, 1, 8'hA0, 0, 0, 0);
      step(0, 1, 8'hA1, 0, 0, 0);
      step(0, 1, 8'hA2, 0, 0, 0);
      chk("t5 level 3 units", 32'(if0.level), 32'd0);
      step(0, 1, 8'hA3, 0, 0, 0);
      chk("t5 level fresh", 32'(if0.level), 32'd1);
      step(0, 0, 8'h00, 0, 1, 0);
      chk("t5 fresh word", if0.rd_data, 32'hA3A2A1A0);
      chk("t5 fresh be", 32'(if0.rd_be), 32'hF);

      // Test 6: show-ahead instance
      do_reset();
      step(1, 1, 8'hEF, 0, 0, 0);
      step(1, 1, 8'hBE, 0, 0, 0);
      step(1, 1, 8'hAD, 0, 0, 0);
      chk("t6 empty rd_data", if1.rd_data, 32'h0);
      chk("t6 empty", 32'(if1.empty), 32'd1);
      step(1, 1, 8'hDE, 0, 0, 0);
      chk("t6 show data", if1.rd_data, 32'hDEADBEEF);
      chk("t6 show be", 32'(if1.rd_be), 32'hF);
      chk("t6 level 1", 32'(if1.level), 32'd1);
      for (int i = 1; i <= 8; i++) begin
         step(1, 1, 8'(i), 0, 0, 0);
      end
      chk("t6 level 3", 32'(if1.level), 32'd3);
      chk("t6 head held", if1.rd_data, 32'hDEADBEEF);
      step(1, 1, 8'h09, 0, 0, 0);
      step(1, 1, 8'h0A, 0, 0, 0);
      step(1, 1, 8'h0B, 0, 0, 0);
      step(1, 1, 8'h0C, 0, 1, 0);
      chk("t6 push+pop level", 32'(if1.level), 32'd3);
      chk("t6 next head", if1.rd_data, 32'h04030201);
      chk("t6 underflow", 32'(if1.underflow), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/qspi_rx_pack_fifo.md
Name: qspi_rx_pack_fifo

Overview:
Single-clock receive-data FIFO for the QSPI read path. It accepts narrow units from the QSPI shift logic (nibble or byte) and packs them little-endian into full AHB-width words. It stores each word with a per-unit valid mask and returns words to the AHB slave side. Compared with the current read FIFO it adds:
- width conversion
- partial-word flush
- programmable almost-full/almost-empty flags
- fill level
- sticky overflow/underflow errors
- soft clear
- selectable show-ahead read mode

Parameters:
- WR_WIDTH, 8: width of one input unit from the QSPI shifter; must divide RD_WIDTH.
- RD_WIDTH, 32: width of one stored/output word.
- FIFO_DEPTH, 16: number of words; power of two, ≥ 2.
- AF_THRESH, FIFO_DEPTH-2: almost_full asserts when level ≥ AF_THRESH.
- AE_THRESH, 1: almost_empty asserts when level ≤ AE_THRESH.
- SHOW_AHEAD, 0: 0 = registered read; 1 = head word visible without rd_en.
- Derived: R = RD_WIDTH/WR_WIDTH; LW = $clog2(FIFO_DEPTH)+1.

Ports:
- clk, in, 1: single clock; all logic on posedge.
- rst_n, in, 1: reset is synchronous and active-high (asserted = 1), despite the name.
- clear, in, 1: synchronous soft flush; same effect as reset except parameters.
- wr_en, in, 1: input unit valid.
- wr_data, in, WR_WIDTH: input unit.
- flush_partial, in, 1: close the current word even if fewer than R units are held.
- wr_ready, out, 1: equals !full; a unit or flush is accepted only when high.
- rd_en, in, 1: pop head word.
- rd_data, out, RD_WIDTH: read word.
- rd_be, out, R: per-unit valid mask of the read word; bit i covers unit i.
- full, out, 1: level == FIFO_DEPTH.
- empty, out, 1: level == 0.
- almost_full, out, 1: level ≥ AF_THRESH.
- almost_empty, out, 1: level ≤ AE_THRESH.
- level, out, LW: stored word count; excludes the packer contents.
- overflow, out, 1: sticky; wr_en or flush_partial while !wr_ready.
- underflow, out, 1: sticky; rd_en while empty.

Behaviour:
- Reset/clear (rst_n or clear high at the edge):
  - Pointers, level and packer count go to 0; packer data is discarded.
  - rd_data = 0, rd_be = 0, overflow = 0, underflow = 0.
  - Resulting flags: empty = 1, full = 0, wr_ready = 1, almost_empty = 1, almost_full = 0.
  - clear has priority over every same-cycle operation.
  - Reset or clear asserted mid-packing discards the partial word.
- Packer:
  - Holds pack_cnt (0..R-1) units. Unit k goes to bits [k*WR_WIDTH +: WR_WIDTH].
  - On an accepted wr_en, the unit is written at slot pack_cnt.
  - When pack_cnt == R-1, the completed word (assembled combinationally with the incoming unit) is pushed on the same edge with rd_be = all ones, and pack_cnt returns to 0.
- Partial flush:
  - Accepted flush_partial pushes the held units plus any same-cycle accepted unit.
  - Unused slots are zero-filled; rd_be marks only the valid units. pack_cnt returns to 0.
  - If no units are held and there is no same-cycle wr_en, flush is a no-op: no push.
  - If the same-cycle unit completes the word, exactly one full word is pushed.
- Write gating:
  - wr_en or flush_partial while full: input dropped, overflow set, packer unchanged.
  - A write is never accepted against a same-cycle pop; there is no pass-through.
- Write-to-read latency: a word pushed at edge N gives empty = 0 and level incremented in cycle N+1.
- Read, SHOW_AHEAD = 0:
  - rd_en && !empty at edge N loads rd_data/rd_be from the head and advances the pointer.
  - Data is valid in cycle N+1. Otherwise rd_data/rd_be hold.
- Read, SHOW_AHEAD = 1:
  - rd_data/rd_be combinationally show the head word when !empty, and show 0 when empty.
  - rd_en && !empty advances the pointer.
- rd_en while empty: no pointer change, data holds, underflow set.
- Simultaneous push and pop (both legal): level unchanged; both pointers advance.
- Level and pointer arithmetic:
  - level is a registered up/down counter: push only +1, pop only −1, both or neither 0.
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally from FIFO_DEPTH-1 to 0.
  - All flags are derived combinationally from the registered level.

Decomposition:
- Package qspi_fifo_pkg:
  - Default widths and depth.
  - Function calculating R.
  - Typedef of the stored entry struct {data, be}.
  - Elaboration-time check that WR_WIDTH divides RD_WIDTH.
- Sub-module qspi_rx_packer: pack_cnt, accumulation, flush/zero-fill, and push/entry generation.
- Top module: storage array, pointers, level, flags, sticky errors, read mode.

Test Plan:
1. Reset, then 8 bytes 0x11..0x88 with no reads → level = 2; reads return 0x44332211 then 0x88776655, rd_be = 4'hF; then empty = 1.
2. 3 bytes 0xAA, 0xBB, 0xCC, then flush_partial alone → one word 0x00CCBBAA with rd_be = 4'h7. A further flush_partial with no held units → level unchanged.
3. Fill 16 words (64 bytes, AF_THRESH = 14) → almost_full from level 14, full at 16, wr_ready = 0. A 65th wr_en → overflow = 1, level stays 16. First read still returns word 0.
4. Steady stream, one byte per cycle, with rd_en whenever a word is available → no overflow/underflow; level ≤ 1. Pointers wrap past 15 with data order preserved over 40 words.
5. rd_en on empty after reset → underflow = 1, rd_data stays 0. Then clear → underflow = 0. Assert clear with 2 bytes held and 5 words stored → level = 0, next 4 bytes form a fresh word.
6. SHOW_AHEAD = 1: push 0xDEADBEEF → rd_data = 0xDEADBEEF in cycle N+1 before any rd_en. Simultaneous push and pop at level 3 → level stays 3.
